// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: next-PC select codes,
// reset PC / ROM size defaults and the opcode/funct values the stall unit decodes.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BEQ = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IMEM_AW_DEFAULT  = 10;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    // Word-aligned, sign-extended branch offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection from the instruction currently in ID.
// Redirect targets are computed from the ID-stage PC; the fall-through is pc_F+4.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [25:0] ir_d_i,
    input  npc_op_e     npc_op_i,
    input  logic        cmp_eq_i,
    input  logic [31:0] rs_val_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc;
    logic [31:0] beq_pc;
    logic [31:0] jmp_pc;

    assign seq_pc = pc_f_i + 32'd4;
    assign beq_pc = pc_d_i + 32'd4 + branch_offset(ir_d_i[15:0]);
    assign jmp_pc = {pc_d_i[31:28], ir_d_i, 2'b00};

    always_comb begin
        npc_o = seq_pc;
        case (npc_op_i)
            NPC_SEQ: npc_o = seq_pc;
            NPC_BEQ: npc_o = cmp_eq_i ? beq_pc : seq_pc;
            NPC_J:   npc_o = jmp_pc;
            NPC_JR:  npc_o = rs_val_i;
            default: npc_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with the IF/ID pipeline register; the branch delay slot is architectural,
// so redirects never flush IF/ID. Optional FETCH_STALL_CNT_EN adds stall/issue counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stop,
    input  logic [1:0]         npc_op,
    input  logic               cmp_eq_D,
    input  logic [31:0]        rs_val_D,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        IR_D,
    output logic [31:0]        PC_D,
    output logic [31:0]        PC8_D,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic [31:0]        pc_F
);

    logic [31:0] pc_q,  pc_d;
    logic [31:0] ir_q,  ir_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc8_q, pc8_d;
    logic [31:0] npc;

    npc_calc u_npc_calc (
        .pc_f_i   (pc_q),
        .pc_d_i   (pcd_q),
        .ir_d_i   (ir_q[25:0]),
        .npc_op_i (npc_op_e'(npc_op)),
        .cmp_eq_i (cmp_eq_D),
        .rs_val_i (rs_val_D),
        .npc_o    (npc)
    );

    // ROM is indexed relative to the reset PC; higher bits wrap modulo its depth.
    assign imem_addr = IMEM_AW'((pc_q - PC_RESET) >> 2);

    // stop freezes the whole stage; the held IR_D re-presents any pending redirect.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        pcd_d = pcd_q;
        pc8_d = pc8_q;
        if (!stop) begin
            pc_d  = npc;
            ir_d  = imem_rdata;
            pcd_d = pc_q;
            pc8_d = pc_q + 32'd8;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] issue_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            issue_cnt   <= 32'd0;
        end else if (stop) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            issue_cnt   <= issue_cnt + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= 32'd0;
            pcd_q <= PC_RESET;
            pc8_q <= PC_RESET + 32'd8;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            pcd_q <= pcd_d;
            pc8_q <= pc8_d;
        end
    end

    assign pc_F  = pc_q;
    assign IR_D  = ir_q;
    assign PC_D  = pcd_q;
    assign PC8_D = pc8_q;

endmodule
